// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | alu_arbiter_pkg : ALU control codes, FSM encoding, latency default  |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
package alu_arbiter_pkg;

  localparam int unsigned DEFAULT_MUL_LAT = 2;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd10;
  localparam logic [3:0] ALU_SLT = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only the multiply waits for the pipelined multiplier; everything else is one cycle.
  function automatic logic [2:0] exec_cycles(input logic [3:0] ctl, input logic [2:0] mul_lat);
    return (ctl == ALU_MUL) ? mul_lat : 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin grant, one-hot, purely combinational  |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | alu_arbiter : shares one external ALU between two requesters        |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_ctl,
  input  logic        req0_sign,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_ctl,
  input  logic        req1_sign,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  input  logic        resp1_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctl,
  output logic        alu_sign,
  input  logic [31:0] alu_out,
  output logic        busy
);

  localparam logic [2:0] MUL_CYCLES = 3'(MUL_LAT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;

  logic [1:0]  grant;
  logic [1:0]  ready;
  logic        resp_fire;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is suppressed while reset is asserted so no handshake can slip in.
  assign ready      = (state_q == ST_IDLE && !reset) ? grant : 2'b00;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign resp_fire  = (state_q == ST_RESP) && (owner_q ? resp1_ready : resp0_ready);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    ctl_d        = ctl_q;
    sign_d       = sign_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (|ready) begin
          owner_d = ready[1];
          in1_d   = ready[1] ? req1_in1  : req0_in1;
          in2_d   = ready[1] ? req1_in2  : req0_in2;
          ctl_d   = ready[1] ? req1_ctl  : req0_ctl;
          sign_d  = ready[1] ? req1_sign : req0_sign;
          count_d = 3'd1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (count_q == exec_cycles(ctl_q, MUL_CYCLES)) begin
          result_d = alu_out;
          count_d  = 3'd0;
          state_d  = ST_RESP;
        end else begin
          count_d = count_q + 3'd1;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= 3'd0;
      in1_q        <= 32'd0;
      in2_q        <= 32'd0;
      ctl_q        <= 4'd0;
      sign_q       <= 1'b0;
      result_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      ctl_q        <= ctl_d;
      sign_q       <= sign_d;
      result_q     <= result_d;
    end
  end

  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_ctl     = ctl_q;
  assign alu_sign    = sign_q;
  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign resp0_data  = resp0_valid ? result_q : 32'd0;
  assign resp1_data  = resp1_valid ? result_q : 32'd0;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_alu_arbiter : scoreboard bench with a behavioural shared ALU     |
// | rev 1.0                                                             |
// +---------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [3:0]  req0_ctl = '0, req1_ctl = '0;
  logic        req0_sign = 1'b0, req1_sign = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_ctl;
  logic        alu_sign, busy;

  alu_arbiter #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_ctl(req0_ctl), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_ctl(req1_ctl), .req1_sign(req1_sign),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c, input logic s);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_MUL: return a * b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $signed(a) >>> b[4:0];
      ALU_SLT: return {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_out = alu_ref(alu_in1, alu_in2, alu_ctl, alu_sign);

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pushes expectations on every handshake, checks every response cycle.
  initial begin
    logic        held [2];
    logic        rv [2], rr [2], hv [2];
    logic [31:0] rd [2], a [2], b [2];
    logic [3:0]  c [2];
    logic        s [2];
    exp_t        e;
    held[0] = 1'b0;
    held[1] = 1'b0;
    forever begin
      @(negedge clk);
      rv = '{resp0_valid, resp1_valid};
      rr = '{resp0_ready, resp1_ready};
      rd = '{resp0_data, resp1_data};
      hv = '{req0_valid && req0_ready, req1_valid && req1_ready};
      a  = '{req0_in1, req1_in1};
      b  = '{req0_in2, req1_in2};
      c  = '{req0_ctl, req1_ctl};
      s  = '{req0_sign, req1_sign};
      if (reset) begin
        held[0] = 1'b0;
        held[1] = 1'b0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (hv[n]) begin
            e.id   = n;
            e.data = alu_ref(a[n], b[n], c[n], s[n]);
            e.due  = cyc + ((c[n] == ALU_MUL) ? 1 + LAT : 2);
            sb.push_back(e);
            grant_log.push_back(n);
          end
        end
        for (int n = 0; n < 2; n++) begin
          if (rv[n]) begin
            total++;
            if (sb.size() == 0 || sb[0].id != n) begin
              bad++;
              $display("FAIL resp%0d_unexpected: valid=1 at cycle %0d, no pending transaction", n, cyc);
            end else begin
              if (!held[n]) begin
                total++;
                if (cyc != sb[0].due) begin
                  bad++;
                  $display("FAIL resp%0d_latency: rose at cycle %0d, expected %0d", n, cyc, sb[0].due);
                end
              end
              total++;
              if (rd[n] !== sb[0].data) begin
                bad++;
                $display("FAIL resp%0d_data: got %h expected %h", n, rd[n], sb[0].data);
              end
              total++;
              if (rd[1-n] !== 32'd0) begin
                bad++;
                $display("FAIL resp%0d_idle_data: got %h expected 0", 1 - n, rd[1-n]);
              end
              if (rr[n]) sb.delete(0);
            end
            held[n] = !rr[n];
          end else begin
            held[n] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic s);
    if (id == 0) begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_ctl = c; req0_sign = s;
    end else begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_ctl = c; req1_sign = s;
    end
  endtask

  // Presents a request, waits (bounded) for its handshake, then withdraws valid.
  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic s);
    int n = 0;
    logic rdy;
    set_req(id, 1'b1, a, b, c, s);
    do begin
      @(negedge clk);
      n++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 50);
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send%0d_timeout: ready=0 after %0d cycles, expected 1", id, n);
    end
    tick();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < 200);
    if (sb.size() != 0 || busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d busy=%b, expected 0/0", sb.size(), busy);
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    total++;
    if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_resp_valid: got %b expected 00", {resp0_valid, resp1_valid});
    end
    total++;
    if ({resp0_data, resp1_data} !== 64'd0) begin
      bad++; $display("FAIL reset_resp_data: got %h/%h expected 0/0", resp0_data, resp1_data);
    end
    total++;
    if ({alu_in1, alu_in2, alu_ctl, alu_sign} !== 69'd0) begin
      bad++; $display("FAIL reset_alu_outs: got %h %h %h %b expected all 0", alu_in1, alu_in2, alu_ctl, alu_sign);
    end
    tick();
  endtask

  task automatic test_add();
    resp0_ready = 1'b1;
    send(0, 32'd5, 32'd7, ALU_ADD, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (busy !== (k <= 2)) begin bad++; $display("FAIL add_busy_T+%0d: got %b expected %b", k, busy, k <= 2); end
      if (k < 3) tick();
    end
    tick();
  endtask

  task automatic test_mul();
    int n = 0;
    resp1_ready = 1'b1;
    resp0_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b0);
    send(1, 32'd6, 32'd7, ALU_MUL, 1'b0);
    for (int k = 1; k <= 1 + LAT; k++) begin
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b0) begin bad++; $display("FAIL mul_req0_ready_T+%0d: got %b expected 0", k, req0_ready); end
      tick();
    end
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    total++;
    if (!req0_ready) begin bad++; $display("FAIL mul_req0_regrant: ready=0 expected 1"); end
    tick();
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_fairness();
    int n = 0;
    int exp_id;
    do_reset();
    grant_log.delete();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, 32'd10, 32'd1, ALU_ADD, 1'b0);
    set_req(1, 1'b1, 32'd20, 32'd3, ALU_SUB, 1'b0);
    while (grant_log.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      exp_id = i % 2;
      total++;
      if (i >= grant_log.size()) begin
        bad++; $display("FAIL fair_grant%0d: no grant expected %0d", i, exp_id);
      end else if (grant_log[i] != exp_id) begin
        bad++; $display("FAIL fair_grant%0d: got %0d expected %0d", i, grant_log[i], exp_id);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int g;
    resp0_ready = 1'b0;
    send(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b1);
    set_req(1, 1'b1, 32'd2, 32'd2, ALU_ADD, 1'b0);
    g = grant_log.size();
    do begin
      @(negedge clk);
      n++;
    end while (!resp0_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (resp0_valid !== 1'b1 || resp0_data !== 32'd1) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h expected 1/00000001", i, resp0_valid, resp0_data);
      end
      total++;
      if (req1_ready !== 1'b0) begin bad++; $display("FAIL bp_no_grant%0d: req1_ready=%b expected 0", i, req1_ready); end
    end
    tick();
    resp0_ready = 1'b1;
    req1_valid = 1'b0;
    wait_idle();
    total++;
    if (grant_log.size() != g) begin
      bad++; $display("FAIL bp_grant_count: got %0d expected %0d", grant_log.size(), g);
    end
    send(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b0);
    wait_idle();
  endtask

  task automatic test_reset_abort();
    resp0_ready = 1'b1;
    send(0, 32'd3, 32'd4, ALU_MUL, 1'b0);
    reset = 1'b1;
    sb.delete();
    set_req(0, 1'b1, 32'd2, 32'd2, ALU_ADD, 1'b0);
    tick();
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset: got %b expected 0", req0_ready); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (resp0_valid !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b expected 0", resp0_valid); end
    total++;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL abort_regrant: got %b expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_operand_change();
    resp1_ready = 1'b1;
    send(1, 32'd3, 32'd1, ALU_SUB, 1'b0);
    req1_in1 = 32'd9;
    req1_ctl = ALU_ADD;
    req1_sign = 1'b1;
    @(negedge clk);
    total++;
    if (alu_in1 !== 32'd3 || alu_ctl !== ALU_SUB) begin
      bad++; $display("FAIL opchg_alu_regs: in1=%h ctl=%h expected 3/1", alu_in1, alu_ctl);
    end
    tick();
    wait_idle();
  endtask

  task automatic test_valid_drop();
    int g;
    resp1_ready = 1'b1;
    g = grant_log.size();
    send(1, 32'd40, 32'd2, ALU_SRL, 1'b0);
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b0);
    tick();
    req0_valid = 1'b0;
    wait_idle();
    total++;
    if (grant_log.size() != g + 1) begin
      bad++; $display("FAIL drop_grants: got %0d expected %0d", grant_log.size() - g, 1);
    end
  endtask

  task automatic test_ops();
    logic [3:0] ops [12];
    ops = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA, 4'd3, 4'd13,
            ALU_SLT, ALU_ADD, ALU_MUL};
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(i % 2, $urandom, $urandom, ops[i], 1'($urandom_range(0, 1)));
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_fairness();
    test_backpressure();
    test_reset_abort();
    test_operand_change();
    test_valid_drop();
    test_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 2, SHALL set the cycles from operand launch to a valid multiplier result for ALUCtl code 2 (legal range 1-7).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_in1, reqN_in2  input  32 each  operands.
REQ-007 reqN_ctl  input  4  ALU control code; reqN_sign  input  1  signed-compare select.
REQ-008 respN_valid  output  1  result for requester N held.
REQ-009 respN_data  output  32  result value.
REQ-010 respN_ready  input  1  requester N takes the result.
REQ-011 alu_in1, alu_in2  output  32 each; alu_ctl  output  4; alu_sign  output  1  drive the shared ALU.
REQ-012 alu_out  input  32  shared ALU result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 In IDLE, reqN_ready SHALL be high only for the granted requester, combinationally from the valids and the last_grant register.
REQ-016 Grant rule: only one valid -> that requester; both valid -> the requester not equal to last_grant.
REQ-017 A handshake (valid & ready) SHALL latch in1, in2, ctl, sign and the owner ID into operand registers, and move to EXEC.
REQ-018 The alu_* outputs SHALL be driven only from the operand registers, never directly from req inputs.
REQ-019 EXEC SHALL count cycles from 1: exit when count = MUL_LAT for ctl = 2, or count = 1 for any other ctl.
REQ-020 On EXEC exit, alu_out SHALL be captured into the result register and the FSM SHALL move to RESP.
REQ-021 Latency, handshake at cycle T: respN_valid SHALL rise at T+2 for non-multiply ops and at T+1+MUL_LAT for multiply.
REQ-022 In RESP, respN_valid SHALL be high for the owner only, and respN_data SHALL equal the result register; the other requester's data SHALL be 0.
REQ-023 respN_valid and data SHALL remain stable until respN_ready; on respN_valid & respN_ready the FSM SHALL return to IDLE and set last_grant to the owner.
REQ-024 No new request SHALL be accepted in EXEC or RESP: both ready outputs low, one transaction outstanding.
REQ-025 Undefined ctl codes (3, 12-15) SHALL use the 1-cycle path; the result is whatever the ALU returns (0).
REQ-026 reqN_valid dropping before handshake SHALL be legal, with no side effect.
REQ-027 Operand, ctl and sign changes on a requester after handshake SHALL have no effect on the transaction in flight.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE and last_grant SHALL be 1 (requester 0 wins the first tie).
REQ-029 On reset, the count, operand and result registers SHALL clear to 0; all ready and resp outputs SHALL be 0, alu_* outputs 0, busy 0.
REQ-030 Reset in EXEC or RESP SHALL abort the transaction with no response issued; reqN_ready SHALL be low during the reset cycle.

Structure
REQ-031 A shared package SHALL hold:
- ALU control code constants: ADD=0, SUB=1, MUL=2, AND=4, OR=5, XOR=6, NOR=7, SLL=8, SRL=9, SRA=10, SLT=11;
- the FSM state encoding;
- the MUL_LAT default.
REQ-032 Grant selection SHALL live in a sub-module, rr_arb2: 2 valids and last_grant in, one-hot grant out, purely combinational.

Verification
REQ-033 Single add: req0 in1=5, in2=7, ctl=0 at T; resp0_ready=1 -> resp0_valid at T+2, data=12; busy high T+1..T+2.
REQ-034 Multiply, MUL_LAT=2: req1 in1=6, in2=7, ctl=2 at T -> resp1_valid at T+3, data=42; req0 stays not-ready until IDLE.
REQ-035 Tie fairness: both valid continuously with resp_ready=1 -> grants alternate 0,1,0,1; first grant goes to 0 after reset.
REQ-036 Backpressure: resp0_ready=0 for 5 cycles on SLT with in1=0xFFFFFFFF, in2=1, sign=1 -> data held at 1 for all cycles, no new grant; sign=0 yields 0.
REQ-037 Reset mid-EXEC of a multiply -> no resp_valid follows; next request completes normally with correct latency.
REQ-038 Operand change after handshake: in1 changed from 3 to 9 during EXEC on SUB, in2=1 -> result 2.
